tekbot_drive_ctrl: RTL

- Parametrised successor to the Tekbot remote button-to-motor decoder.
- Synchronises and debounces three drive buttons and two bump switches, then decodes them into left/right motor enable/direction.
- Adds PWM speed control on the drive enables and an autonomous bump-recovery manoeuvre: back up, then turn away.
- Sits between the remote/bumper pins and the motor driver H-bridge inputs.

---
 rtl/tekbot_pkg.sv | 51 +++++
 rtl/tekbot_debounce.sv | 52 +++++
 rtl/tekbot_drive_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/tekbot_pkg.sv
// Shared types and constants for the Tekbot drive controller: FSM states,
// motor direction encodings, button bit positions and the drive-decode helper.
package tekbot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    BACKUP = 2'd2,
    TURN   = 2'd3
  } state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  localparam int BTN_L = 2;
  localparam int BTN_F = 1;
  localparam int BTN_R = 0;

  typedef struct packed {
    logic l_en;
    logic l_dir;
    logic r_en;
    logic r_dir;
  } drive_t;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // L and R together win over either alone; F only matters with no side pressed.
  function automatic drive_t decode_buttons(input logic [2:0] b);
    drive_t d;
    d.l_en  = 1'b1;
    d.r_en  = 1'b1;
    d.l_dir = DIR_FWD;
    d.r_dir = DIR_FWD;
    if (b[BTN_L] && b[BTN_R]) begin
      d.l_dir = DIR_REV;
      d.r_dir = DIR_REV;
    end else if (b[BTN_L]) begin
      d.l_dir = DIR_REV;
    end else if (b[BTN_R]) begin
      d.r_dir = DIR_REV;
    end else if (!b[BTN_F]) begin
      d.l_en = 1'b0;
      d.r_en = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/tekbot_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw input.
module tekbot_debounce
  import tekbot_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic deb_o
);

  localparam int CNT_W = clog2_min1(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle agreeing with the current output restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/tekbot_drive_ctrl.sv
// Tekbot drive controller: debounced buttons/bumpers -> PWM motor drive with
// bump recovery (back up, then turn away). Optional ramp: TEKBOT_SOFTSTART_EN.
module tekbot_drive_ctrl
  import tekbot_pkg::*;
#(
  parameter int DEB_CYCLES    = 4,
  parameter int PWM_W         = 4,
  parameter int BACKUP_CYCLES = 16,
  parameter int TURN_CYCLES   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       btn,
  input  logic             bump_l,
  input  logic             bump_r,
  input  logic [PWM_W-1:0] duty,
  output logic             l_en,
  output logic             l_dir,
  output logic             r_en,
  output logic             r_dir,
  output logic             busy
);

  localparam int BK_W  = clog2_min1(BACKUP_CYCLES);
  localparam int TN_W  = clog2_min1(TURN_CYCLES);
  localparam int CNT_W = (BK_W > TN_W) ? BK_W : TN_W;
  localparam logic [CNT_W-1:0] BK_LAST  = CNT_W'(BACKUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TN_LAST  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [PWM_W-1:0] PWM_LAST = '1;

  logic [4:0] raw_vec;
  logic [4:0] deb_vec;
  logic [2:0] deb_btn;
  logic       deb_bl;
  logic       deb_br;

  assign raw_vec = {btn, bump_l, bump_r};

  for (genvar i = 0; i < 5; i++) begin : g_deb
    tekbot_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .raw_i  (raw_vec[i]),
      .deb_o  (deb_vec[i])
    );
  end

  assign deb_btn = deb_vec[4:2];
  assign deb_bl  = deb_vec[1];
  assign deb_br  = deb_vec[0];

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] man_cnt_q;
  logic [CNT_W-1:0] man_cnt_d;
  logic             side_l_q;
  logic             side_l_d;
  logic             side_r_q;
  logic             side_r_d;
  logic [1:0]       bump_prev_q;
  logic             bump_rise;
  logic [PWM_W-1:0] pwm_cnt_q;
  logic [PWM_W-1:0] eff_duty_q;
  logic [PWM_W-1:0] eff_duty_d;
  logic [PWM_W-1:0] eff_now;
  logic             pwm_wrap;
  drive_t           btn_drive;
  drive_t           drv_q;
  drive_t           drv_d;
  logic             busy_q;
  logic             busy_d;

  // Tracking the previous level every cycle means a bump held through a
  // manoeuvre cannot retrigger once it ends.
  assign bump_rise = (deb_bl & ~bump_prev_q[1]) | (deb_br & ~bump_prev_q[0]);
  assign pwm_wrap  = (pwm_cnt_q == PWM_LAST);
  assign btn_drive = decode_buttons(deb_btn);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    man_cnt_d = man_cnt_q;
    side_l_d  = side_l_q;
    side_r_d  = side_r_q;
    case (state_q)
      IDLE, DRIVE: begin
        if (bump_rise) begin
          state_d   = BACKUP;
          man_cnt_d = '0;
          side_l_d  = deb_bl;
          side_r_d  = deb_br;
        end else begin
          state_d = (|deb_btn) ? DRIVE : IDLE;
        end
      end
      BACKUP: begin
        if (man_cnt_q == BK_LAST) begin
          state_d   = TURN;
          man_cnt_d = '0;
        end else begin
          man_cnt_d = man_cnt_q + CNT_W'(1);
        end
      end
      TURN: begin
        if (man_cnt_q == TN_LAST) begin
          state_d   = (|deb_btn) ? DRIVE : IDLE;
          man_cnt_d = '0;
        end else begin
          man_cnt_d = man_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TEKBOT_SOFTSTART_EN
  logic entering_drive;
  assign entering_drive = (state_d == DRIVE) && (state_q != DRIVE);
  assign eff_now        = entering_drive ? '0 : eff_duty_q;

  always_comb begin
    eff_duty_d = eff_duty_q;
    if (entering_drive) begin
      eff_duty_d = '0;
    end else if (pwm_wrap) begin
      if (duty < eff_duty_q) begin
        eff_duty_d = duty;
      end else if (eff_duty_q < duty) begin
        eff_duty_d = eff_duty_q + PWM_W'(1);
      end
    end
  end
`else
  assign eff_now = eff_duty_q;

  always_comb begin
    eff_duty_d = pwm_wrap ? duty : eff_duty_q;
  end
`endif

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    drv_d      = drv_q;
    drv_d.l_en = 1'b0;
    drv_d.r_en = 1'b0;
    busy_d     = 1'b0;
    case (state_d)
      DRIVE: begin
        drv_d.l_en  = btn_drive.l_en & (pwm_cnt_q < eff_now);
        drv_d.r_en  = btn_drive.r_en & (pwm_cnt_q < eff_now);
        drv_d.l_dir = btn_drive.l_dir;
        drv_d.r_dir = btn_drive.r_dir;
      end
      BACKUP: begin
        drv_d  = '{l_en: 1'b1, l_dir: DIR_REV, r_en: 1'b1, r_dir: DIR_REV};
        busy_d = 1'b1;
      end
      TURN: begin
        if (side_l_q || !side_r_q) begin
          drv_d = '{l_en: 1'b1, l_dir: DIR_FWD, r_en: 1'b1, r_dir: DIR_REV};
        end else begin
          drv_d = '{l_en: 1'b1, l_dir: DIR_REV, r_en: 1'b1, r_dir: DIR_FWD};
        end
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      man_cnt_q   <= '0;
      side_l_q    <= 1'b0;
      side_r_q    <= 1'b0;
      bump_prev_q <= 2'b00;
      pwm_cnt_q   <= '0;
      eff_duty_q  <= '0;
      drv_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      man_cnt_q   <= man_cnt_d;
      side_l_q    <= side_l_d;
      side_r_q    <= side_r_d;
      bump_prev_q <= {deb_bl, deb_br};
      pwm_cnt_q   <= pwm_cnt_q + PWM_W'(1);
      eff_duty_q  <= eff_duty_d;
      drv_q       <= drv_d;
      busy_q      <= busy_d;
    end
  end

  assign l_en  = drv_q.l_en;
  assign l_dir = drv_q.l_dir;
  assign r_en  = drv_q.r_en;
  assign r_dir = drv_q.r_dir;
  assign busy  = busy_q;

endmodule
